bayer_demosaic_2x2: RTL and testbench
=====================================

// Module: bayer_demosaic_2x2
//
// PURPOSE
//  Upstream stage of the greyscale/convolution path. Turns a raw Bayer sensor stream
//  (GRBG, one 12-bit sample per valid) into 12-bit RGB pixels for the convolution wrapper.
//  Each 2x2 Bayer quad collapses into one RGB pixel, so output resolution is W/2 x H/2.
//  One even raw row is buffered in a line buffer and paired with the following odd row.
//
// PARAMETERS
//  IMG_WIDTH  1280  raw samples per line; must be even, >= 4
//  DATA_W     12    raw/colour sample width (taken from pixel_pkg)
//
// PORTS
//  i_clk    in   1       clock
//  i_rst    in   1       synchronous reset, active-high
//  i_raw    in   DATA_W  raw Bayer sample
//  i_valid  in   1       i_raw valid this cycle (no backpressure; gaps allowed)
//  i_sof    in   1       qualified by i_valid: this sample is row 0, col 0
//  o_red    out  DATA_W  demosaiced red
//  o_green  out  DATA_W  demosaiced green
//  o_blue   out  DATA_W  demosaiced blue
//  o_valid  out  1       single-cycle strobe, RGB valid
//  o_sof    out  1       with o_valid: first output pixel of the frame
//
// BEHAVIOUR
//  - Reset: o_red/o_green/o_blue = 0, o_valid = 0, o_sof = 0, col = 0, row_odd = 0,
//    first_pending = 1; held G1/B registers cleared. Line buffer contents are don't-care.
//  - Counters advance only on i_valid.
//    - col: 0..IMG_WIDTH-1. At IMG_WIDTH-1 it wraps to 0 and toggles row_odd.
//    - i_valid && i_sof forces this sample to col=0, row_odd=0 and sets first_pending.
//      The next sample is col 1. Any half-built quad is dropped.
//  - Bayer layout (GRBG):
//    - even row: G1 at even col, R at odd col
//    - odd row:  B at even col, G2 at odd col
//  - Even row, even col: hold G1 in a register.
//  - Even row, odd col: write {G1,R} to line buffer at address col>>1.
//  - Odd row, even col: hold B; issue line-buffer read at address col>>1.
//    Read has 1-cycle latency; read data stays stable until the next read.
//  - Odd row, odd col (G2 accepted), on the next clock:
//    - o_red = R, o_blue = B
//    - o_green = (G1 + G2) >> 1, using a DATA_W+1 sum; truncate, no rounding.
//    - o_valid = 1 for exactly one cycle.
//    - o_sof = first_pending; first_pending then clears.
//  - Latency: o_valid one cycle after the odd-row odd-col input. Throughput: one output
//    per 2 odd-row inputs; zero outputs during even rows.
//  - RGB outputs hold their last value while o_valid = 0.
//  - i_valid gaps between B and G2 are legal; the result is unchanged.
//  - Simultaneous G2 and i_sof: i_sof wins. That sample is treated as row-0 G1 and no
//    output is produced.
//  - Reset mid-frame: counters restart at row 0, col 0. No output until the next odd row
//    completes its first quad.
//
// STRUCTURE
//  - pixel_pkg:
//    - localparam DATA_W = 12
//    - typedef rgb_t  (struct: r, g, b of DATA_W)
//    - typedef bayer_pair_t  (struct: g1, r)
//  - Sub-module line_buffer #(DEPTH=IMG_WIDTH/2, WIDTH=2*DATA_W):
//    - simple dual-port sync RAM, 1-cycle registered read, read data held between reads
//    - should map to M9K
//  - Top: col/row counters, G1/B holding registers, first_pending flag, output register.
//
// TESTING  (IMG_WIDTH=4 unless noted)
//  1. Reset: hold i_rst 2 cycles mid-stream -> all outputs 0. No o_valid until an even
//     row plus odd quad arrive.
//  2. Basic quad, i_sof on first sample:
//     - row0 = 100,200,100,200; row1 = 300,102,300,102
//     - -> 2 outputs R=200 G=101 B=300, each one cycle after cols 1 and 3 of row1
//     - o_sof high only on the first output
//  3. Green truncation: G1=4095, G2=4094 -> o_green=4094 (8189>>1). G1=G2=0 -> 0.
//  4. Gaps: i_valid low 5 cycles between B and G2 -> identical output. o_valid stays low
//     during the gap.
//  5. Resync: i_sof asserted on row1 col1 -> no output for it. The next even/odd row pair
//     yields outputs, with o_sof high on the first one.
//  6. Full width: IMG_WIDTH=1280 ramp frame, 4 rows -> 1280 outputs.
//     - Compared against a reference model.
//     - Line-buffer address wrap at 639->0 checked.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared pixel types for the greyscale/convolution path: sample width,
// RGB pixel struct and the even-row Bayer pair held in the line buffer.
package pixel_pkg;

  localparam int DATA_W = 12;

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic [DATA_W-1:0] g1;
    logic [DATA_W-1:0] r;
  } bayer_pair_t;

  // Average of the two greens, truncated; the sum is carried at DATA_W+1 bits.
  function automatic logic [DATA_W-1:0] green_avg(input logic [DATA_W-1:0] g1,
                                                  input logic [DATA_W-1:0] g2);
    logic [DATA_W:0] sum;
    sum = {1'b0, g1} + {1'b0, g2};
    return sum[DATA_W:1];
  endfunction

endpackage

// File: rtl/bayer_demosaic_2x2_line_buffer.sv
// Simple dual-port synchronous RAM holding one even raw row as {G1,R} pairs.
// Registered read with one-cycle latency; read data holds between reads.
module line_buffer #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 24,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      rdata_q <= mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/bayer_demosaic_2x2.sv
// GRBG Bayer stream to RGB: each 2x2 quad becomes one pixel, the even row
// is parked in a line buffer and combined with the following odd row.
module bayer_demosaic_2x2
  import pixel_pkg::*;
#(
  parameter int IMG_WIDTH = 1280
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_raw,
  input  logic              i_valid,
  input  logic              i_sof,
  output logic [DATA_W-1:0] o_red,
  output logic [DATA_W-1:0] o_green,
  output logic [DATA_W-1:0] o_blue,
  output logic              o_valid,
  output logic              o_sof
);

  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ADDR_W = $clog2(IMG_WIDTH / 2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  logic [COL_W-1:0]  col_q, col_d;
  logic              row_odd_q, row_odd_d;
  logic              first_pending_q, first_pending_d;
  logic [DATA_W-1:0] g1_q, g1_d;
  logic [DATA_W-1:0] b_q, b_d;
  rgb_t              pix_q, pix_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;

  logic              sof_s;
  logic [COL_W-1:0]  col_eff_s;
  logic              row_eff_s;
  logic              lb_we_s;
  logic              lb_re_s;
  logic [ADDR_W-1:0] lb_addr_s;
  bayer_pair_t       wr_pair_s;
  bayer_pair_t       rd_pair_s;
  logic [2*DATA_W-1:0] rd_data_s;

  assign rd_pair_s = bayer_pair_t'(rd_data_s);

  // Position of the current sample; i_sof overrides the counters so a resync
  // drops whatever half-built quad was in flight.
  always_comb begin
    sof_s     = i_valid && i_sof;
    col_eff_s = sof_s ? '0 : col_q;
    row_eff_s = sof_s ? 1'b0 : row_odd_q;
    lb_addr_s = col_eff_s[ADDR_W:1];
  end

  // Counter advance, quad assembly and output pixel formation.
  always_comb begin
    col_d           = col_q;
    row_odd_d       = row_odd_q;
    first_pending_d = first_pending_q;
    g1_d            = g1_q;
    b_d             = b_q;
    pix_d           = pix_q;
    valid_d         = 1'b0;
    sof_d           = 1'b0;
    lb_we_s         = 1'b0;
    lb_re_s         = 1'b0;
    wr_pair_s.g1    = g1_q;
    wr_pair_s.r     = i_raw;

    if (i_valid) begin
      if (col_eff_s == COL_LAST) begin
        col_d     = '0;
        row_odd_d = ~row_eff_s;
      end else begin
        col_d     = col_eff_s + COL_W'(1);
        row_odd_d = row_eff_s;
      end

      if (sof_s) begin
        first_pending_d = 1'b1;
      end else begin
        first_pending_d = first_pending_q;
      end

      case ({row_eff_s, col_eff_s[0]})
        2'b00: g1_d = i_raw;
        2'b01: lb_we_s = 1'b1;
        2'b10: begin
          b_d     = i_raw;
          lb_re_s = 1'b1;
        end
        2'b11: begin
          // Read issued on the B sample has landed by now, even across gaps.
          pix_d.r         = rd_pair_s.r;
          pix_d.g         = green_avg(rd_pair_s.g1, i_raw);
          pix_d.b         = b_q;
          valid_d         = 1'b1;
          sof_d           = first_pending_q;
          first_pending_d = 1'b0;
        end
        default: begin
          g1_d = g1_q;
        end
      endcase
    end else begin
      col_d = col_q;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q           <= '0;
      row_odd_q       <= 1'b0;
      first_pending_q <= 1'b1;
      g1_q            <= '0;
      b_q             <= '0;
      pix_q           <= '0;
      valid_q         <= 1'b0;
      sof_q           <= 1'b0;
    end else begin
      col_q           <= col_d;
      row_odd_q       <= row_odd_d;
      first_pending_q <= first_pending_d;
      g1_q            <= g1_d;
      b_q             <= b_d;
      pix_q           <= pix_d;
      valid_q         <= valid_d;
      sof_q           <= sof_d;
    end
  end

  line_buffer #(
    .DEPTH  (IMG_WIDTH / 2),
    .WIDTH  (2 * DATA_W),
    .ADDR_W (ADDR_W)
  ) u_line_buffer (
    .i_clk   (i_clk),
    .i_we    (lb_we_s),
    .i_waddr (lb_addr_s),
    .i_wdata (wr_pair_s),
    .i_re    (lb_re_s),
    .i_raddr (lb_addr_s),
    .o_rdata (rd_data_s)
  );

  assign o_red   = pix_q.r;
  assign o_green = pix_q.g;
  assign o_blue  = pix_q.b;
  assign o_valid = valid_q;
  assign o_sof   = sof_q;

endmodule

// File: tb/tb_bayer_demosaic_2x2.sv
// Directed bench for bayer_demosaic_2x2: a narrow instance (IMG_WIDTH=4) for
// the quad scenarios and a full-width instance for the ramp frame.
module tb_bayer_demosaic_2x2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] raw = 12'd0;
  logic        sof = 1'b0;
  logic        valid4 = 1'b0;
  logic        validw = 1'b0;

  logic [11:0] red4, green4, blue4, redw, greenw, bluew;
  logic        o_valid4, o_sof4, o_validw, o_sofw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bayer_demosaic_2x2 #(.IMG_WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_raw(raw), .i_valid(valid4), .i_sof(sof),
    .o_red(red4), .o_green(green4), .o_blue(blue4), .o_valid(o_valid4), .o_sof(o_sof4)
  );

  bayer_demosaic_2x2 #(.IMG_WIDTH(1280)) dutw (
    .i_clk(clk), .i_rst(rst), .i_raw(raw), .i_valid(validw), .i_sof(sof),
    .o_red(redw), .o_green(greenw), .o_blue(bluew), .o_valid(o_validw), .o_sof(o_sofw)
  );

  task automatic send4(input logic [11:0] d, input logic s);
    @(negedge clk);
    raw = d; sof = s; valid4 = 1'b1;
    @(posedge clk);
    #1;
    valid4 = 1'b0; sof = 1'b0;
  endtask

  task automatic sendw(input logic [11:0] d, input logic s);
    @(negedge clk);
    raw = d; sof = s; validw = 1'b1;
    @(posedge clk);
    #1;
    validw = 1'b0; sof = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] v [8];
    checks++;
    if ({red4, green4, blue4, o_valid4, o_sof4} !== 38'd0 ||
        {redw, greenw, bluew, o_validw, o_sofw} !== 38'd0) begin
      errors++;
      $display("FAIL reset_init got %h/%h exp 0", {red4, green4, blue4, o_valid4, o_sof4},
               {redw, greenw, bluew, o_validw, o_sofw});
    end
    v = '{12'd1, 12'd2, 12'd1, 12'd2, 12'd3, 12'd4, 12'd0, 12'd0};
    for (int i = 0; i < 6; i++) send4(v[i], i == 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({red4, green4, blue4, o_valid4, o_sof4} !== 38'd0) begin
      errors++;
      $display("FAIL reset_mid got %h exp 0", {red4, green4, blue4, o_valid4, o_sof4});
    end
    @(negedge clk); rst = 1'b0;
    v = '{12'd10, 12'd20, 12'd10, 12'd20, 12'd30, 12'd12, 12'd30, 12'd12};
    for (int i = 0; i < 8; i++) begin
      send4(v[i], 1'b0);
      checks++;
      if (o_valid4 !== (i == 5 || i == 7)) begin
        errors++;
        $display("FAIL reset_valid[%0d] got %b exp %b", i, o_valid4, (i == 5 || i == 7));
      end
      if (i == 5 || i == 7) begin
        checks++;
        if ({red4, green4, blue4, o_sof4} !== {12'd20, 12'd11, 12'd30, (i == 5)}) begin
          errors++;
          $display("FAIL reset_pix[%0d] got %0d/%0d/%0d sof %b exp 20/11/30 sof %b",
                   i, red4, green4, blue4, o_sof4, (i == 5));
        end
      end
    end
  endtask

  task automatic test_basic();
    logic [11:0] v [8];
    v = '{12'd100, 12'd200, 12'd100, 12'd200, 12'd300, 12'd102, 12'd300, 12'd102};
    for (int i = 0; i < 8; i++) begin
      send4(v[i], i == 0);
      checks++;
      if (o_valid4 !== (i == 5 || i == 7)) begin
        errors++;
        $display("FAIL basic_valid[%0d] got %b exp %b", i, o_valid4, (i == 5 || i == 7));
      end
      if (i == 5 || i == 7) begin
        checks++;
        if ({red4, green4, blue4} !== {12'd200, 12'd101, 12'd300}) begin
          errors++;
          $display("FAIL basic_pix[%0d] got %0d/%0d/%0d exp 200/101/300", i, red4, green4, blue4);
        end
        checks++;
        if (o_sof4 !== (i == 5)) begin
          errors++;
          $display("FAIL basic_sof[%0d] got %b exp %b", i, o_sof4, (i == 5));
        end
      end
    end
  endtask

  task automatic test_green_trunc();
    logic [11:0] v [8];
    v = '{12'd4095, 12'd7, 12'd0, 12'd9, 12'd5, 12'd4094, 12'd6, 12'd0};
    for (int i = 0; i < 8; i++) begin
      send4(v[i], 1'b0);
      if (i == 5) begin
        checks++;
        if ({o_valid4, o_sof4, red4, green4, blue4} !== {1'b1, 1'b0, 12'd7, 12'd4094, 12'd5}) begin
          errors++;
          $display("FAIL trunc_max got v%b s%b %0d/%0d/%0d exp v1 s0 7/4094/5",
                   o_valid4, o_sof4, red4, green4, blue4);
        end
      end
      if (i == 7) begin
        checks++;
        if ({o_valid4, red4, green4, blue4} !== {1'b1, 12'd9, 12'd0, 12'd6}) begin
          errors++;
          $display("FAIL trunc_zero got v%b %0d/%0d/%0d exp v1 9/0/6",
                   o_valid4, red4, green4, blue4);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic [11:0] v [4];
    v = '{12'd50, 12'd60, 12'd50, 12'd60};
    for (int i = 0; i < 4; i++) send4(v[i], 1'b0);
    for (int q = 0; q < 2; q++) begin
      send4(12'd70, 1'b0);
      for (int g = 0; g < 5; g++) begin
        idle();
        checks++;
        if (o_valid4 !== 1'b0) begin
          errors++;
          $display("FAIL gap_valid[%0d.%0d] got %b exp 0", q, g, o_valid4);
        end
      end
      send4(12'd52, 1'b0);
      checks++;
      if ({o_valid4, red4, green4, blue4} !== {1'b1, 12'd60, 12'd51, 12'd70}) begin
        errors++;
        $display("FAIL gap_pix[%0d] got v%b %0d/%0d/%0d exp v1 60/51/70",
                 q, o_valid4, red4, green4, blue4);
      end
    end
    idle();
    checks++;
    if ({o_valid4, red4, green4, blue4} !== {1'b0, 12'd60, 12'd51, 12'd70}) begin
      errors++;
      $display("FAIL gap_hold got v%b %0d/%0d/%0d exp v0 60/51/70", o_valid4, red4, green4, blue4);
    end
  endtask

  task automatic test_resync();
    logic [11:0] v [8];
    v = '{12'd11, 12'd22, 12'd11, 12'd22, 12'd33, 12'd0, 12'd0, 12'd0};
    for (int i = 0; i < 5; i++) send4(v[i], 1'b0);
    send4(12'd1000, 1'b1);
    checks++;
    if (o_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL resync_drop got %b exp 0", o_valid4);
    end
    v = '{12'd2000, 12'd1000, 12'd2000, 12'd3000, 12'd1002, 12'd3000, 12'd1002, 12'd0};
    for (int i = 0; i < 7; i++) begin
      send4(v[i], 1'b0);
      checks++;
      if (o_valid4 !== (i == 4 || i == 6)) begin
        errors++;
        $display("FAIL resync_valid[%0d] got %b exp %b", i, o_valid4, (i == 4 || i == 6));
      end
      if (i == 4 || i == 6) begin
        checks++;
        if ({red4, green4, blue4, o_sof4} !== {12'd2000, 12'd1001, 12'd3000, (i == 4)}) begin
          errors++;
          $display("FAIL resync_pix[%0d] got %0d/%0d/%0d sof %b exp 2000/1001/3000 sof %b",
                   i, red4, green4, blue4, o_sof4, (i == 4));
        end
      end
    end
  endtask

  function automatic logic [11:0] ramp(input int r, input int c);
    return 12'((r * 1237 + c * 5) % 4096);
  endfunction

  task automatic test_full_width();
    int outs = 0;
    logic [12:0] gsum;
    logic [11:0] er, eg, eb;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 1280; c++) begin
        sendw(ramp(r, c), (r == 0 && c == 0));
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          gsum = {1'b0, ramp(r - 1, c - 1)} + {1'b0, ramp(r, c)};
          er = ramp(r - 1, c);
          eg = gsum[12:1];
          eb = ramp(r, c - 1);
          if (o_validw === 1'b1) outs++;
          checks++;
          if ({o_validw, o_sofw, redw, greenw, bluew} !==
              {1'b1, (r == 1 && c == 1), er, eg, eb}) begin
            errors++;
            $display("FAIL wide_pix r%0d c%0d got v%b s%b %0d/%0d/%0d exp v1 s%b %0d/%0d/%0d",
                     r, c, o_validw, o_sofw, redw, greenw, bluew, (r == 1 && c == 1), er, eg, eb);
          end
        end else if (o_validw !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL wide_valid r%0d c%0d got %b exp 0", r, c, o_validw);
        end
      end
    end
    checks++;
    if (outs != 1280) begin
      errors++;
      $display("FAIL wide_count got %0d exp 1280", outs);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_green_trunc();
    test_gaps();
    test_resync();
    test_full_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  end

endmodule
